// File: rtl/core_dbg_regs_if.sv
// Debug bus interface for core_dbg_regs.
// The master issues single-cycle requests: dbg_req with dbg_we, dbg_addr and dbg_wdata.
// The slave answers each read one cycle later on dbg_rvalid/dbg_rdata.
interface core_dbg_regs_if #(
  parameter int unsigned DBG_ADDR_WIDTH = 4,
  parameter int unsigned DBG_DATA_WIDTH = 32
);
  logic                      dbg_req;
  logic                      dbg_we;
  logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
  logic [DBG_DATA_WIDTH-1:0] dbg_wdata;
  logic                      dbg_rvalid;
  logic [DBG_DATA_WIDTH-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rvalid, dbg_rdata
  );
endinterface

// File: rtl/core_dbg_regs.sv
// Core debug register block.
// Register map (word offsets):
//   0 DBGSC    : status, sticky error bits 3..5 cleared by writing 1
//   1 DRUNCTRL : bit0 halt, bit1 resume, bit2 step (reads 0)
//   2+k        : ITRk, writing the last one launches the ITR sequence
//   2+ITR_NUM+j: DTR word j, word 0 is the most significant
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   dbg               debug bus (slave side)
//   core_halt_req_o   level halt request; core_resume_o/core_step_o one-cycle pulses
//   core_halted_i     core halted status; core_step_done_i step retired pulse
//   itr_valid_o/itr_ready_i/itr_insn_o  instruction stream; itr_done_i last insn retired
//   core_dtr_we_i/core_dtr_wdata_i      core DTR write; dtr_value_o current DTR
module core_dbg_regs #(
  parameter int unsigned ITR_NUM        = 4,
  parameter int unsigned INSN_WIDTH     = 32,
  parameter int unsigned REG_WIDTH      = 64,
  parameter int unsigned DBG_DATA_WIDTH = 32,
  parameter int unsigned DBG_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_dbg_regs_if.slave        dbg,
  output logic                  core_halt_req_o,
  output logic                  core_resume_o,
  output logic                  core_step_o,
  input  logic                  core_halted_i,
  input  logic                  core_step_done_i,
  output logic                  itr_valid_o,
  input  logic                  itr_ready_i,
  output logic [INSN_WIDTH-1:0] itr_insn_o,
  input  logic                  itr_done_i,
  input  logic                  core_dtr_we_i,
  input  logic [REG_WIDTH-1:0]  core_dtr_wdata_i,
  output logic [REG_WIDTH-1:0]  dtr_value_o
);

  localparam int unsigned DTR_WORDS = REG_WIDTH / DBG_DATA_WIDTH;
  localparam int unsigned ItrBase   = 2;
  localparam int unsigned DtrBase   = 2 + ITR_NUM;
  localparam int unsigned IdxW      = (ITR_NUM > 1) ? $clog2(ITR_NUM) : 1;

  typedef enum logic [2:0] {
    StRun, StHaltWait, StHalted, StResumeWait, StStepWait
  } run_state_e;

  run_state_e state_q, state_d;

  logic                  resume_q, resume_d;
  logic                  step_q, step_d;
  logic [INSN_WIDTH-1:0] itr_q [ITR_NUM];
  logic [INSN_WIDTH-1:0] itr_d [ITR_NUM];
  logic                  busy_q, busy_d;
  logic                  issue_q, issue_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [REG_WIDTH-1:0]  dtr_q, dtr_d;
  logic                  full_q, full_d;
  // {err_run, err_dtr, err_itr}
  logic [2:0]            err_q, err_d;
  logic                  rvalid_q, rvalid_d;
  logic [DBG_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [31:0] addr_ext;
  logic [DBG_DATA_WIDTH-1:0] wdata;
  logic wr, rd, sel_sc, sel_rc;
  logic [ITR_NUM-1:0]   sel_itr;
  logic [DTR_WORDS-1:0] sel_dtr;
  logic halt_cmd, resume_cmd, step_cmd, multi_cmd;
  logic err_run_set, err_itr_set, err_dtr_set;

  assign addr_ext = 32'(dbg.dbg_addr);
  assign wdata    = dbg.dbg_wdata;
  assign wr       = dbg.dbg_req & dbg.dbg_we;
  assign rd       = dbg.dbg_req & ~dbg.dbg_we;
  assign sel_sc   = (addr_ext == 32'd0);
  assign sel_rc   = (addr_ext == 32'd1);

  always_comb begin
    sel_itr = '0;
    sel_dtr = '0;
    for (int k = 0; k < ITR_NUM; k++) sel_itr[k] = (addr_ext == ItrBase + 32'(k));
    for (int j = 0; j < DTR_WORDS; j++) sel_dtr[j] = (addr_ext == DtrBase + 32'(j));
  end

  // With several DRUNCTRL bits set only halt is honoured.
  assign multi_cmd  = $countones(wdata[2:0]) > 1;
  assign halt_cmd   = wr & sel_rc & wdata[0];
  assign resume_cmd = wr & sel_rc & wdata[1] & ~multi_cmd;
  assign step_cmd   = wr & sel_rc & wdata[2] & ~multi_cmd;

  // Run-control FSM
  always_comb begin
    state_d     = state_q;
    resume_d    = 1'b0;
    step_d      = 1'b0;
    err_run_set = (resume_cmd | step_cmd) & ((state_q != StHalted) | busy_q);
    unique case (state_q)
      StRun:        if (halt_cmd) state_d = StHaltWait;
      StHaltWait:   if (core_halted_i) state_d = StHalted;
      StHalted: begin
        if (!busy_q) begin
          if (resume_cmd) begin
            state_d  = StResumeWait;
            resume_d = 1'b1;
          end else if (step_cmd) begin
            state_d = StStepWait;
            step_d  = 1'b1;
          end
        end
      end
      StResumeWait: if (!core_halted_i) state_d = StRun;
      StStepWait:   if (core_step_done_i) state_d = StHalted;
      default:      state_d = StRun;
    endcase
  end

  // ITR storage and issue
  always_comb begin
    itr_d       = itr_q;
    busy_d      = busy_q;
    issue_d     = issue_q;
    idx_d       = idx_q;
    err_itr_set = 1'b0;
    if (issue_q && itr_ready_i) begin
      if (idx_q == IdxW'(ITR_NUM - 1)) issue_d = 1'b0;
      else                             idx_d   = idx_q + 1'b1;
    end
    if (busy_q && itr_done_i) busy_d = 1'b0;
    for (int k = 0; k < ITR_NUM; k++) begin
      if (wr && sel_itr[k]) begin
        if (busy_q || ((k == ITR_NUM - 1) && (state_q != StHalted))) begin
          err_itr_set = 1'b1;
        end else begin
          itr_d[k] = wdata[INSN_WIDTH-1:0];
          if (k == ITR_NUM - 1) begin
            busy_d  = 1'b1;
            issue_d = 1'b1;
            idx_d   = '0;
          end
        end
      end
    end
  end

  // DTR: a core write always wins over a host write in the same cycle.
  always_comb begin
    dtr_d       = dtr_q;
    full_d      = full_q;
    err_dtr_set = 1'b0;
    for (int j = 0; j < DTR_WORDS; j++) begin
      if (wr && sel_dtr[j]) begin
        if (core_dtr_we_i) err_dtr_set = 1'b1;
        else dtr_d[REG_WIDTH-1-j*DBG_DATA_WIDTH -: DBG_DATA_WIDTH] = wdata;
      end
    end
    if (rd && sel_dtr[DTR_WORDS-1]) full_d = 1'b0;
    if (core_dtr_we_i) begin
      dtr_d  = core_dtr_wdata_i;
      full_d = 1'b1;
    end
  end

  // Sticky errors: a new event in the same cycle beats a clear.
  always_comb begin
    err_d = err_q;
    if (wr && sel_sc) err_d = err_q & ~wdata[5:3];
    err_d = err_d | {err_run_set, err_dtr_set, err_itr_set};
  end

  // Read path
  always_comb begin
    rvalid_d = rd;
    rdata_d  = '0;
    if (rd) begin
      if (sel_sc) rdata_d[5:0] = {err_q, full_q, busy_q, state_q == StHalted};
      for (int k = 0; k < ITR_NUM; k++) begin
        if (sel_itr[k]) rdata_d[INSN_WIDTH-1:0] = itr_q[k];
      end
      for (int j = 0; j < DTR_WORDS; j++) begin
        if (sel_dtr[j]) rdata_d = dtr_q[REG_WIDTH-1-j*DBG_DATA_WIDTH -: DBG_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      resume_q <= 1'b0;
      step_q   <= 1'b0;
      for (int k = 0; k < ITR_NUM; k++) itr_q[k] <= '0;
      busy_q   <= 1'b0;
      issue_q  <= 1'b0;
      idx_q    <= '0;
      dtr_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      step_q   <= step_d;
      itr_q    <= itr_d;
      busy_q   <= busy_d;
      issue_q  <= issue_d;
      idx_q    <= idx_d;
      dtr_q    <= dtr_d;
      full_q   <= full_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign core_halt_req_o = (state_q == StHaltWait) || (state_q == StHalted);
  assign core_resume_o   = resume_q;
  assign core_step_o     = step_q;
  assign itr_valid_o     = issue_q;
  assign itr_insn_o      = issue_q ? itr_q[idx_q] : '0;
  assign dtr_value_o     = dtr_q;
  assign dbg.dbg_rvalid  = rvalid_q;
  assign dbg.dbg_rdata   = rdata_q;

endmodule

// File: tb/tb_core_dbg_regs.sv
module tb_core_dbg_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_halt_req, core_resume, core_step;
  logic        core_halted = 1'b0, core_step_done = 1'b0;
  logic        itr_valid, itr_ready = 1'b0, itr_done = 1'b0;
  logic [31:0] itr_insn;
  logic        core_dtr_we = 1'b0;
  logic [63:0] core_dtr_wdata = '0;
  logic [63:0] dtr_value;

  int total = 0;
  int bad   = 0;

  core_dbg_regs_if #(.DBG_ADDR_WIDTH(4), .DBG_DATA_WIDTH(32)) dbg_if ();

  core_dbg_regs #(
    .ITR_NUM(4), .INSN_WIDTH(32), .REG_WIDTH(64), .DBG_DATA_WIDTH(32), .DBG_ADDR_WIDTH(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dbg              (dbg_if),
    .core_halt_req_o  (core_halt_req),
    .core_resume_o    (core_resume),
    .core_step_o      (core_step),
    .core_halted_i    (core_halted),
    .core_step_done_i (core_step_done),
    .itr_valid_o      (itr_valid),
    .itr_ready_i      (itr_ready),
    .itr_insn_o       (itr_insn),
    .itr_done_i       (itr_done),
    .core_dtr_we_i    (core_dtr_we),
    .core_dtr_wdata_i (core_dtr_wdata),
    .dtr_value_o      (dtr_value)
  );

  always #5 clk = ~clk;

  // Collect every accepted ITR instruction.
  logic [31:0] got [8];
  int          ngot = 0;
  always @(posedge clk) begin
    if (itr_valid && itr_ready) begin
      if (ngot < 8) got[ngot] = itr_insn;
      ngot = ngot + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t reset_tbl [16];
  vec_t dtr_tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    dbg_if.dbg_req   = 1'b1;
    dbg_if.dbg_we    = 1'b1;
    dbg_if.dbg_addr  = addr;
    dbg_if.dbg_wdata = data;
    @(negedge clk);
    dbg_if.dbg_req   = 1'b0;
    dbg_if.dbg_we    = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [3:0] addr,
                                input logic [31:0] exp);
    @(negedge clk);
    dbg_if.dbg_req  = 1'b1;
    dbg_if.dbg_we   = 1'b0;
    dbg_if.dbg_addr = addr;
    @(negedge clk);
    dbg_if.dbg_req  = 1'b0;
    check({name, " rvalid"}, 64'(dbg_if.dbg_rvalid), 64'd1);
    check(name, 64'(dbg_if.dbg_rdata), 64'(exp));
  endtask

  task automatic run_vec(input string name, input vec_t v);
    if (v.we) bus_write(v.addr, v.wdata);
    else      bus_read_check(name, v.addr, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) reset_tbl[i] = '{we: 1'b0, addr: 4'(i), wdata: '0, exp: '0};
    dtr_tbl[0] = '{we: 1'b0, addr: 4'd0, wdata: '0, exp: 32'h5};
    dtr_tbl[1] = '{we: 1'b0, addr: 4'd6, wdata: '0, exp: 32'h11223344};
    dtr_tbl[2] = '{we: 1'b0, addr: 4'd0, wdata: '0, exp: 32'h5};
    dtr_tbl[3] = '{we: 1'b0, addr: 4'd7, wdata: '0, exp: 32'h55667788};
    dtr_tbl[4] = '{we: 1'b0, addr: 4'd0, wdata: '0, exp: 32'h1};

    dbg_if.dbg_req = 1'b0; dbg_if.dbg_we = 1'b0; dbg_if.dbg_addr = '0; dbg_if.dbg_wdata = '0;

    // Reset values
    #12;
    check("rst halt_req", 64'(core_halt_req), 64'd0);
    check("rst resume", 64'(core_resume), 64'd0);
    check("rst step", 64'(core_step), 64'd0);
    check("rst itr_valid", 64'(itr_valid), 64'd0);
    check("rst itr_insn", 64'(itr_insn), 64'd0);
    check("rst dtr", dtr_value, 64'd0);
    check("rst rvalid", 64'(dbg_if.dbg_rvalid), 64'd0);
    check("rst rdata", 64'(dbg_if.dbg_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("reset read %0d", i), reset_tbl[i]);
    @(negedge clk);
    check("rvalid one cycle", 64'(dbg_if.dbg_rvalid), 64'd0);

    // Halt, core acknowledges after 3 cycles
    bus_write(4'd1, 32'h1);
    for (int c = 0; c < 3; c++) begin
      check("halt_req in HALT_WAIT", 64'(core_halt_req), 64'd1);
      @(negedge clk);
    end
    core_halted = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("halt_req in HALTED", 64'(core_halt_req), 64'd1);
    bus_read_check("DBGSC halted", 4'd0, 32'h1);

    // ITR sequence with toggling ready
    bus_write(4'd2, 32'h13);
    bus_write(4'd3, 32'h93);
    bus_write(4'd4, 32'h113);
    ngot = 0;
    bus_write(4'd5, 32'h193);
    check("itr_valid after trigger", 64'(itr_valid), 64'd1);
    for (int c = 0; c < 30 && ngot < 4; c++) begin
      itr_ready = (c % 2) == 1;
      @(negedge clk);
    end
    itr_ready = 1'b0;
    check("itr handshake count", 64'(ngot), 64'd4);
    check("itr insn 0", 64'(got[0]), 64'h13);
    check("itr insn 1", 64'(got[1]), 64'h93);
    check("itr insn 2", 64'(got[2]), 64'h113);
    check("itr insn 3", 64'(got[3]), 64'h193);
    check("itr_valid after last", 64'(itr_valid), 64'd0);
    bus_read_check("DBGSC busy", 4'd0, 32'h3);
    bus_write(4'd2, 32'hdead);
    bus_read_check("DBGSC err_itr", 4'd0, 32'hB);
    @(negedge clk);
    itr_done = 1'b1;
    @(negedge clk);
    itr_done = 1'b0;
    bus_read_check("DBGSC after done", 4'd0, 32'h9);
    bus_write(4'd0, 32'h8);
    bus_read_check("DBGSC err_itr cleared", 4'd0, 32'h1);

    // DTR core write and host readout
    @(negedge clk);
    core_dtr_we = 1'b1;
    core_dtr_wdata = 64'h1122334455667788;
    @(negedge clk);
    core_dtr_we = 1'b0;
    check("dtr core load", dtr_value, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) run_vec($sformatf("dtr vec %0d", i), dtr_tbl[i]);

    // Same-cycle core and host write
    @(negedge clk);
    core_dtr_we = 1'b1;
    core_dtr_wdata = 64'hAABBCCDDEEFF0011;
    dbg_if.dbg_req = 1'b1; dbg_if.dbg_we = 1'b1;
    dbg_if.dbg_addr = 4'd7; dbg_if.dbg_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    core_dtr_we = 1'b0;
    dbg_if.dbg_req = 1'b0; dbg_if.dbg_we = 1'b0;
    check("dtr collision core wins", dtr_value, 64'hAABBCCDDEEFF0011);
    bus_read_check("DBGSC err_dtr", 4'd0, 32'h15);
    bus_read_check("dtr lo after collision", 4'd7, 32'hEEFF0011);
    bus_write(4'd0, 32'h10);
    bus_write(4'd7, 32'h12345678);
    check("dtr host slice write", dtr_value, 64'hAABBCCDD12345678);
    bus_read_check("DBGSC after dtr clear", 4'd0, 32'h1);

    // Single step, resume during STEP_WAIT is an error
    bus_write(4'd1, 32'h4);
    check("step pulse", 64'(core_step), 64'd1);
    @(negedge clk);
    check("step pulse ends", 64'(core_step), 64'd0);
    bus_write(4'd1, 32'h2);
    check("no resume in STEP_WAIT", 64'(core_resume), 64'd0);
    bus_read_check("DBGSC step_wait err_run", 4'd0, 32'h20);
    @(negedge clk);
    core_step_done = 1'b1;
    @(negedge clk);
    core_step_done = 1'b0;
    bus_read_check("DBGSC step done", 4'd0, 32'h21);
    bus_write(4'd0, 32'h20);
    bus_read_check("DBGSC err_run cleared", 4'd0, 32'h1);

    // Multi-bit DRUNCTRL in HALTED: only halt acts, so nothing happens
    bus_write(4'd1, 32'h3);
    check("multi-bit no resume", 64'(core_resume), 64'd0);
    bus_read_check("DBGSC multi-bit", 4'd0, 32'h1);

    // Resume
    bus_write(4'd1, 32'h2);
    check("resume pulse", 64'(core_resume), 64'd1);
    check("halt_req drops", 64'(core_halt_req), 64'd0);
    core_halted = 1'b0;
    @(negedge clk);
    check("resume pulse ends", 64'(core_resume), 64'd0);
    bus_read_check("DBGSC running", 4'd0, 32'h0);

    // Halt again, launch ITR, reset mid-issue
    bus_write(4'd1, 32'h1);
    core_halted = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(4'd5, 32'h193);
    check("itr_valid before reset", 64'(itr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("itr_valid in reset", 64'(itr_valid), 64'd0);
    check("halt_req in reset", 64'(core_halt_req), 64'd0);
    @(negedge clk);
    core_halted = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("itr_valid after reset", 64'(itr_valid), 64'd0);
    bus_read_check("DBGSC after reset", 4'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_dbg_regs.md
# core_dbg_regs

Parametrised core debug-interface register block: implements the debug register map (DBGSC, DRUNCTRL, ITR0..ITRn-1, DTR words) for a configurable number of instruction-transfer registers and DTR width. Sits between the external debug bus and the core pipeline. It runs a halt/resume/step run-control FSM and streams ITR instructions into the core with a valid/ready handshake. It also exchanges a REG_WIDTH data-transfer register with the core.

## Interface
- ITR_NUM, 4, number of ITR registers; writing the last one triggers execution (≥1)
- INSN_WIDTH, 32, instruction width
- REG_WIDTH, 64, DTR width; DTR_WORDS = REG_WIDTH/DBG_DATA_WIDTH (integer)
- DBG_DATA_WIDTH, 32, debug bus data width (≥ INSN_WIDTH)
- DBG_ADDR_WIDTH, 4, debug bus word address width (≥ clog2(2+ITR_NUM+DTR_WORDS))
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dbg_req  in  1  bus access strobe
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  DBG_ADDR_WIDTH  register offset
- dbg_wdata  in  DBG_DATA_WIDTH  write data
- dbg_rvalid  out  1  read data valid
- dbg_rdata  out  DBG_DATA_WIDTH  read data
- core_halt_req  out  1  level halt request
- core_resume  out  1  one-cycle resume pulse
- core_step  out  1  one-cycle single-step pulse
- core_halted  in  1  core is halted
- core_step_done  in  1  pulse: stepped instruction retired, core re-halted
- itr_valid  out  1  ITR instruction valid
- itr_ready  in  1  core accepts instruction
- itr_insn  out  INSN_WIDTH  instruction
- itr_done  in  1  pulse: last ITR instruction retired
- core_dtr_we  in  1  core writes DTR
- core_dtr_wdata  in  REG_WIDTH  core DTR data
- dtr_value  out  REG_WIDTH  current DTR contents

## Operation
- Map: 0 DBGSC, 1 DRUNCTRL, 2+k ITRk, 2+ITR_NUM+j DTR word j (j=0 most significant). Other offsets: reads return 0, writes are ignored.
- DBGSC read: bit0 halted (run FSM in HALTED), bit1 itr_busy, bit2 dtr_core_full, bit3 err_itr, bit4 err_dtr, bit5 err_run; other bits 0.
- DBGSC write: a 1 clears the corresponding sticky bit among bits 3..5.
- DRUNCTRL write: bit0 halt, bit1 resume, bit2 step. If more than one bit is set, only halt acts. DRUNCTRL reads return 0.
- Run FSM states: RUN, HALT_WAIT, HALTED, RESUME_WAIT, STEP_WAIT.
  - RUN, halt written → HALT_WAIT.
  - HALT_WAIT: core_halt_req=1 until core_halted=1 → HALTED. core_halt_req stays 1 in HALTED.
  - HALTED, resume written → core_resume pulse, core_halt_req drops, → RESUME_WAIT. Stays there until core_halted=0 → RUN.
  - HALTED, step written → core_step pulse → STEP_WAIT. Stays there until core_step_done → HALTED.
  - Resume or step outside HALTED, or while itr_busy: ignored, err_run set. Halt outside RUN: ignored, no error.
- ITR execution:
  - ITRk holds write data [INSN_WIDTH-1:0]. A write to ITR(ITR_NUM-1) in HALTED with itr_busy=0 sets itr_busy and starts issuing ITR0..ITR(ITR_NUM-1) in order.
  - Each instruction is held on itr_insn with itr_valid=1 until itr_ready.
  - After the last handshake, itr_valid=0. itr_busy clears on itr_done.
  - Any ITR write while itr_busy, or a trigger outside HALTED: write dropped, err_itr set.
- DTR:
  - A host write of word j updates that slice only.
  - core_dtr_we loads the full DTR and sets dtr_core_full. A host read of word DTR_WORDS-1 clears dtr_core_full.
  - If core and host write in the same cycle: the core write wins, the host write is dropped, err_dtr set.
- dbg_req with dbg_we=0 is a read.

## Timing
- Reset values: dbg_rvalid=0, dbg_rdata=0, core_halt_req=0, core_resume=0, core_step=0, itr_valid=0, itr_insn=0, dtr_value=0. All ITRs and sticky bits are 0; the run FSM is in RUN.
- Register writes take effect at the clock edge. Status is visible to a read issued the next cycle.
- Reads: dbg_rvalid=1 and dbg_rdata are valid in the cycle after dbg_req, for exactly one cycle. When dbg_rvalid=0, dbg_rdata=0.
- First itr_valid is asserted in the cycle after the trigger write. With itr_ready held at 1, one instruction is issued per cycle, so ITR_NUM cycles are needed.
- core_resume and core_step are asserted in the cycle after the DRUNCTRL write.
- itr_done arriving in the same cycle as the final handshake: itr_busy clears in that cycle.
- Reset mid-operation aborts ITR issue and pulses immediately. The FSM returns to RUN.

## Test plan
- Reset, then read all offsets 0..15 → all read 0; dbg_rvalid is high one cycle after each request.
- Halt: write DRUNCTRL=1, drive core_halted=1 after 3 cycles → core_halt_req high throughout; DBGSC=0x1.
- ITR: in HALTED, write ITR0..ITR3 = 0x13,0x93,0x113,0x193 with itr_ready toggling → itr_insn sequence is exactly those four values. DBGSC=0x3 until itr_done, then 0x1. An ITR0 write mid-issue sets err_itr (DBGSC bit3).
- DTR: core_dtr_we with 0x1122334455667788 → DTR_HI reads 0x11223344 and DTR_LO reads 0x55667788; bit2 is set before the DTR_LO read and clear after it. A same-cycle host write sets bit4 and the DTR keeps the core value.
- Step: in HALTED write DRUNCTRL=4 → one core_step pulse, then core_step_done → HALTED. A resume written during STEP_WAIT sets err_run.
- Assert rst_n low mid-ITR issue → itr_valid=0 immediately and the FSM is in RUN after release.
